// File: rtl/avl_burst_traffic_gen.sv
// Avalon-MM burst traffic generator/checker: writes N bursts of a counting pattern, reads them back, counts mismatches.
// Optional first-mismatch log enabled by defining AVL_TG_ERR_LOG_EN.
module avl_burst_traffic_gen #(
  parameter int AVL_A_W  = 22,
  parameter int AVL_D_W  = 16,
  parameter int AVL_BE_W = 2,
  parameter int BC_W     = 4,
  parameter int NB_W     = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                csi_clockreset_clk,
  input  logic                csi_clockreset_reset_n,
  input  logic                cfg_start,
  input  logic [AVL_A_W-1:0]  cfg_base_addr,
  input  logic [AVL_A_W-1:0]  cfg_stride,
  input  logic [BC_W-1:0]     cfg_burstlen,
  input  logic [NB_W-1:0]     cfg_num_bursts,
  input  logic [AVL_D_W-1:0]  cfg_seed,
  output logic                sts_busy,
  output logic                sts_done,
  output logic                sts_pass,
  output logic                sts_timeout,
  output logic [15:0]         sts_err_cnt,
  output logic [AVL_A_W-1:0]  avm_m1_address,
  output logic                avm_m1_read,
  output logic                avm_m1_write,
  output logic                avm_m1_beginbursttransfer,
  output logic [BC_W-1:0]     avm_m1_burstcount,
  output logic [AVL_D_W-1:0]  avm_m1_writedata,
  output logic [AVL_BE_W-1:0] avm_m1_byteenable,
  input  logic                avm_m1_waitrequest,
  input  logic                avm_m1_readdatavalid,
  input  logic [AVL_D_W-1:0]  avm_m1_readdata
`ifdef AVL_TG_ERR_LOG_EN
  ,
  output logic [AVL_A_W-1:0]  sts_err_addr,
  output logic [BC_W-1:0]     sts_err_beat,
  output logic [AVL_D_W-1:0]  sts_err_exp,
  output logic [AVL_D_W-1:0]  sts_err_act
`endif
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_DATA, FIN} state_t;

  state_t              state;
  logic [BC_W-1:0]     len_q, beat, start_len;
  logic [NB_W-1:0]     nb_q, burst;
  logic [AVL_A_W-1:0]  base_q, stride_q;
  logic [AVL_D_W-1:0]  seed_q, exp_data;
  logic [15:0]         err_run;
  logic                to_run;
  logic [WD_W-1:0]     wd;
  logic                wr_acc, rd_acc, rd_beat, mismatch, err_inc, active, progress;
`ifdef AVL_TG_ERR_LOG_EN
  logic                logged;
`endif

  assign avm_m1_byteenable = '1;

  always_comb begin
    start_len = (cfg_burstlen == '0) ? BC_W'(1) : cfg_burstlen;
    active    = (state == WR_BURST) || (state == RD_CMD) || (state == RD_DATA);
    wr_acc    = (state == WR_BURST) && avm_m1_write && !avm_m1_waitrequest;
    rd_acc    = (state == RD_CMD) && avm_m1_read && !avm_m1_waitrequest;
    rd_beat   = (state == RD_DATA) && avm_m1_readdatavalid;
    mismatch  = rd_beat && (avm_m1_readdata != exp_data);
    // Unsolicited read data while a command is pending or writes are in flight is also an error.
    err_inc   = mismatch || (avm_m1_readdatavalid && ((state == WR_BURST) || (state == RD_CMD)));
    progress  = wr_acc || rd_acc || rd_beat;
  end

  always_ff @(posedge csi_clockreset_clk) begin
    if (!csi_clockreset_reset_n) begin
      state                     <= IDLE;
      len_q                     <= '0;
      beat                      <= '0;
      nb_q                      <= '0;
      burst                     <= '0;
      base_q                    <= '0;
      stride_q                  <= '0;
      seed_q                    <= '0;
      exp_data                  <= '0;
      err_run                   <= '0;
      to_run                    <= 1'b0;
      wd                        <= '0;
      sts_busy                  <= 1'b0;
      sts_done                  <= 1'b0;
      sts_pass                  <= 1'b0;
      sts_timeout               <= 1'b0;
      sts_err_cnt               <= '0;
      avm_m1_address            <= '0;
      avm_m1_read               <= 1'b0;
      avm_m1_write              <= 1'b0;
      avm_m1_beginbursttransfer <= 1'b0;
      avm_m1_burstcount         <= '0;
      avm_m1_writedata          <= '0;
`ifdef AVL_TG_ERR_LOG_EN
      logged                    <= 1'b0;
      sts_err_addr              <= '0;
      sts_err_beat              <= '0;
      sts_err_exp               <= '0;
      sts_err_act               <= '0;
`endif
    end else begin
      sts_done <= 1'b0;
      if (err_inc && (err_run != '1)) err_run <= err_run + 16'd1;
`ifdef AVL_TG_ERR_LOG_EN
      if (mismatch && !logged) begin
        logged       <= 1'b1;
        sts_err_addr <= avm_m1_address;
        sts_err_beat <= beat;
        sts_err_exp  <= exp_data;
        sts_err_act  <= avm_m1_readdata;
      end
`endif
      case (state)
        IDLE: begin
          if (cfg_start) begin
            len_q    <= start_len;
            nb_q     <= cfg_num_bursts;
            base_q   <= cfg_base_addr;
            stride_q <= cfg_stride;
            seed_q   <= cfg_seed;
            beat     <= '0;
            burst    <= '0;
            err_run  <= '0;
            to_run   <= 1'b0;
            wd       <= '0;
            sts_busy <= 1'b1;
`ifdef AVL_TG_ERR_LOG_EN
            logged       <= 1'b0;
            sts_err_addr <= '0;
            sts_err_beat <= '0;
            sts_err_exp  <= '0;
            sts_err_act  <= '0;
`endif
            if (cfg_num_bursts == '0) begin
              state <= FIN;
            end else begin
              state                     <= WR_BURST;
              avm_m1_write              <= 1'b1;
              avm_m1_beginbursttransfer <= 1'b1;
              avm_m1_address            <= cfg_base_addr;
              avm_m1_burstcount         <= start_len;
              avm_m1_writedata          <= cfg_seed;
            end
          end
        end
        WR_BURST: begin
          avm_m1_beginbursttransfer <= 1'b0;
          // The pattern is contiguous across bursts, so writedata is simply a running counter.
          if (wr_acc) begin
            avm_m1_writedata <= avm_m1_writedata + AVL_D_W'(1);
            if (beat == len_q - BC_W'(1)) begin
              beat                      <= '0;
              avm_m1_beginbursttransfer <= 1'b1;
              if (burst == nb_q - NB_W'(1)) begin
                burst          <= '0;
                avm_m1_write   <= 1'b0;
                avm_m1_read    <= 1'b1;
                avm_m1_address <= base_q;
                exp_data       <= seed_q;
                state          <= RD_CMD;
              end else begin
                burst          <= burst + NB_W'(1);
                avm_m1_address <= avm_m1_address + stride_q;
              end
            end else begin
              beat <= beat + BC_W'(1);
            end
          end
        end
        RD_CMD: begin
          avm_m1_beginbursttransfer <= 1'b0;
          if (rd_acc) begin
            avm_m1_read <= 1'b0;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rd_beat) begin
            exp_data <= exp_data + AVL_D_W'(1);
            if (beat == len_q - BC_W'(1)) begin
              beat <= '0;
              if (burst == nb_q - NB_W'(1)) begin
                state <= FIN;
              end else begin
                burst                     <= burst + NB_W'(1);
                avm_m1_address            <= avm_m1_address + stride_q;
                avm_m1_read               <= 1'b1;
                avm_m1_beginbursttransfer <= 1'b1;
                state                     <= RD_CMD;
              end
            end else begin
              beat <= beat + BC_W'(1);
            end
          end
        end
        FIN: begin
          sts_done          <= 1'b1;
          sts_busy          <= 1'b0;
          sts_pass          <= (err_run == '0) && !to_run;
          sts_timeout       <= to_run;
          sts_err_cnt       <= err_run;
          avm_m1_address    <= '0;
          avm_m1_burstcount <= '0;
          avm_m1_writedata  <= '0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Watchdog overrides the per-state updates above when it expires.
      if (active) begin
        if (progress) begin
          wd <= '0;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          avm_m1_write              <= 1'b0;
          avm_m1_read               <= 1'b0;
          avm_m1_beginbursttransfer <= 1'b0;
          to_run                    <= 1'b1;
          state                     <= FIN;
        end else begin
          wd <= wd + WD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_avl_burst_traffic_gen.sv
// Scoreboard bench for avl_burst_traffic_gen: directed runs against a burst-capable memory slave model.
module tb_avl_burst_traffic_gen;

  localparam int A_W = 22, D_W = 16, BE_W = 2, BC_W = 4, NB_W = 8, TO = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cfg_start;
  logic [A_W-1:0]  cfg_base_addr, cfg_stride;
  logic [BC_W-1:0] cfg_burstlen;
  logic [NB_W-1:0] cfg_num_bursts;
  logic [D_W-1:0]  cfg_seed;
  logic            busy, done, pass, tmo;
  logic [15:0]     err_cnt;
  logic [A_W-1:0]  address;
  logic            read, write, bbt;
  logic [BC_W-1:0] burstcount;
  logic [D_W-1:0]  writedata;
  logic [BE_W-1:0] byteenable;
  logic            waitrequest;
  logic            rdv = 1'b0;
  logic [D_W-1:0]  readdata = '0;
`ifdef AVL_TG_ERR_LOG_EN
  logic [A_W-1:0]  err_addr;
  logic [BC_W-1:0] err_beat;
  logic [D_W-1:0]  err_exp, err_act;
`endif

  always #5 clk = ~clk;

  avl_burst_traffic_gen #(
    .AVL_A_W(A_W), .AVL_D_W(D_W), .AVL_BE_W(BE_W), .BC_W(BC_W), .NB_W(NB_W), .TIMEOUT(TO)
  ) dut (
    .csi_clockreset_clk(clk),
    .csi_clockreset_reset_n(reset_n),
    .cfg_start(cfg_start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_stride(cfg_stride),
    .cfg_burstlen(cfg_burstlen),
    .cfg_num_bursts(cfg_num_bursts),
    .cfg_seed(cfg_seed),
    .sts_busy(busy),
    .sts_done(done),
    .sts_pass(pass),
    .sts_timeout(tmo),
    .sts_err_cnt(err_cnt),
    .avm_m1_address(address),
    .avm_m1_read(read),
    .avm_m1_write(write),
    .avm_m1_beginbursttransfer(bbt),
    .avm_m1_burstcount(burstcount),
    .avm_m1_writedata(writedata),
    .avm_m1_byteenable(byteenable),
    .avm_m1_waitrequest(waitrequest),
    .avm_m1_readdatavalid(rdv),
    .avm_m1_readdata(readdata)
`ifdef AVL_TG_ERR_LOG_EN
    ,
    .sts_err_addr(err_addr),
    .sts_err_beat(err_beat),
    .sts_err_exp(err_exp),
    .sts_err_act(err_act)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected bus/status activity, expected none", name);
  endtask

  // Memory slave model
  logic [15:0] mem [int];
  int stall_data   = -1;
  int stall_cnt    = 0;
  int corrupt_addr = -1;
  bit drop_reads   = 1'b0;
  int rd_q[$];
  int wr_left      = 0;
  int wr_ptr       = 0;

  assign waitrequest = (stall_cnt != 0);

  function automatic logic [15:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= 0;
      rdv       <= 1'b0;
      wr_left = 0;
      rd_q.delete();
    end else begin
      int nxt;
      nxt = (stall_cnt > 0) ? stall_cnt - 1 : 0;
      if (write && !waitrequest) begin
        if (wr_left == 0) begin
          wr_ptr  = int'(address);
          wr_left = int'(burstcount);
        end
        mem[wr_ptr] = writedata;
        wr_ptr++;
        wr_left--;
        if (int'(writedata) == stall_data) nxt = 3;
      end
      stall_cnt <= nxt;
      rdv <= 1'b0;
      if (rd_q.size() > 0 && !drop_reads) begin
        int a;
        a = rd_q.pop_front();
        rdv      <= 1'b1;
        readdata <= mem_rd(a) ^ ((a == corrupt_addr) ? 16'h0100 : 16'h0000);
      end
      if (read && !waitrequest && !drop_reads)
        for (int k = 0; k < int'(burstcount); k++) rd_q.push_back(int'(address) + k);
    end
  end

  // Scoreboard
  typedef struct {
    logic [A_W-1:0]  addr;
    logic [D_W-1:0]  data;
    bit              first;
    logic [BC_W-1:0] len;
  } wexp_t;
  typedef struct {
    logic [A_W-1:0]  addr;
    logic [BC_W-1:0] len;
  } rexp_t;
  typedef struct {
    bit          pass;
    bit          tmo;
    logic [15:0] err;
  } dexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  dexp_t dq[$];
  bit    ignore_bus = 1'b0;
  int    cyc = 0, done_count = 0, done_cyc = 0, rd_acc_cyc = 0, stall_cycles = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset_n && !ignore_bus) begin
      if (write && waitrequest) begin
        stall_cycles++;
        if (wq.size() > 0) chk("wdata_hold", writedata, wq[0].data);
      end
      if (write && !waitrequest) begin
        if (wq.size() == 0) fail_now("unexpected_write");
        else begin
          wexp_t e;
          e = wq.pop_front();
          chk("wdata", writedata, e.data);
          chk("wr_bbt", bbt, e.first);
          if (e.first) begin
            chk("wr_addr", address, e.addr);
            chk("wr_burstcount", burstcount, e.len);
          end
        end
      end
      if (read && !waitrequest) begin
        rd_acc_cyc = cyc;
        if (rq.size() == 0) fail_now("unexpected_read");
        else begin
          rexp_t r;
          r = rq.pop_front();
          chk("rd_addr", address, r.addr);
          chk("rd_burstcount", burstcount, r.len);
          chk("rd_bbt", bbt, 1);
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        if (dq.size() == 0) fail_now("unexpected_done");
        else begin
          dexp_t d;
          d = dq.pop_front();
          chk("done_pass", pass, d.pass);
          chk("done_timeout", tmo, d.tmo);
          chk("done_err_cnt", err_cnt, d.err);
        end
      end
    end
  end

  task automatic plan(input int base, input int stride, input int len, input int nb, input int seed,
                      input bit pass_e, input bit tmo_e, input int err_e);
    int leff;
    leff = (len == 0) ? 1 : len;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < leff; k++)
        wq.push_back('{addr: A_W'(base + b * stride), data: D_W'(seed + b * leff + k),
                       first: (k == 0), len: BC_W'(leff)});
      rq.push_back('{addr: A_W'(base + b * stride), len: BC_W'(leff)});
    end
    dq.push_back('{pass: pass_e, tmo: tmo_e, err: 16'(err_e)});
  endtask

  task automatic start_run(input int base, input int stride, input int len, input int nb, input int seed);
    @(posedge clk);
    #1;
    cfg_base_addr  = A_W'(base);
    cfg_stride     = A_W'(stride);
    cfg_burstlen   = BC_W'(len);
    cfg_num_bursts = NB_W'(nb);
    cfg_seed       = D_W'(seed);
    cfg_start      = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (nb != 0) begin
      chk("write_after_start", write, 1);
      chk("bbt_after_start", bbt, 1);
    end
  endtask

  task automatic wait_done(input int d0, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (done_count != d0) break;
    end
    if (done_count == d0) fail_now("done_wait_expired");
    else begin
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int d0;
    reset_n = 1'b0; cfg_start = 1'b0;
    cfg_base_addr = '0; cfg_stride = '0; cfg_burstlen = '0; cfg_num_bursts = '0; cfg_seed = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);        chk("rst_timeout", tmo, 0);
    chk("rst_err_cnt", err_cnt, 0);  chk("rst_write", write, 0);
    chk("rst_read", read, 0);        chk("rst_bbt", bbt, 0);
    chk("rst_address", address, 0);  chk("rst_burstcount", burstcount, 0);
    chk("rst_writedata", writedata, 0); chk("rst_byteenable", byteenable, 2'b11);

    // 1: single 4-beat burst
    plan(72, 0, 4, 1, 4, 1, 0, 0);
    d0 = done_count; start_run(72, 0, 4, 1, 4); wait_done(d0, 300);
    chk("t1_mem72", mem_rd(72), 4); chk("t1_mem75", mem_rd(75), 7);

    // 2: four strided 8-beat bursts, data 1..32
    plan(0, 256, 8, 4, 1, 1, 0, 0);
    d0 = done_count; start_run(0, 256, 8, 4, 1); wait_done(d0, 500);
    chk("t2_mem0", mem_rd(0), 1); chk("t2_mem256", mem_rd(256), 9); chk("t2_mem775", mem_rd(775), 32);

    // 3: 3-cycle stall after beat 2 is accepted
    stall_cycles = 0; stall_data = 'h22;
    plan(40, 0, 8, 1, 'h20, 1, 0, 0);
    d0 = done_count; start_run(40, 0, 8, 1, 'h20); wait_done(d0, 300);
    stall_data = -1;
    chk("t3_stall_cycles", stall_cycles, 3); chk("t3_mem47", mem_rd(47), 'h27);

    // 4: read beat 2 of burst 1 corrupted
    corrupt_addr = 118;
    plan(16, 100, 8, 2, 'h1000, 0, 0, 1);
    d0 = done_count; start_run(16, 100, 8, 2, 'h1000); wait_done(d0, 300);
    corrupt_addr = -1;
`ifdef AVL_TG_ERR_LOG_EN
    chk("t4_err_addr", err_addr, 116); chk("t4_err_beat", err_beat, 2);
    chk("t4_err_exp", err_exp, 'h100A); chk("t4_err_act", err_act, 'h110A);
`endif

    // 5: slave never returns read data
    drop_reads = 1'b1;
    plan(300, 0, 4, 1, 9, 0, 1, 0);
    d0 = done_count; start_run(300, 0, 4, 1, 9); wait_done(d0, 400);
    drop_reads = 1'b0;
    chk_range("t5_done_latency", done_cyc - rd_acc_cyc, 64, 68);

    // 6: reset mid-burst, then an empty run
    ignore_bus = 1'b1;
    start_run(0, 16, 8, 4, 0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    wq.delete(); rq.delete(); dq.delete();
    ignore_bus = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);       chk("t6_write", write, 0);
    chk("t6_read", read, 0);       chk("t6_bbt", bbt, 0);
    chk("t6_address", address, 0); chk("t6_burstcount", burstcount, 0);
    chk("t6_writedata", writedata, 0); chk("t6_pass", pass, 0);
    d0 = done_count;
    repeat (3) @(negedge clk);
    chk("t6_no_done_after_reset", done_count, d0);
    dq.push_back('{pass: 1'b1, tmo: 1'b0, err: 16'h0});
    d0 = done_count; start_run(0, 0, 0, 0, 0); wait_done(d0, 4);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
